reg_pipe_chain: RTL and testbench

//   Parametrised successor of the single-stage register/bypass cell used on the DSP48A1 operand paths.

---
 rtl/dsp48_pkg.sv | 20 ++
 rtl/reg_pipe_chain_if.sv | 31 +++
 rtl/reg_pipe_chain_pipe_stage.sv | 33 +++
 rtl/reg_pipe_chain.sv | 89 ++++++++
 tb/tb_reg_pipe_chain.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dsp48_pkg.sv
// Shared definitions for the DSP48-style operand path blocks.
// Holds the width helper, reset-type tags and default operand width.
package dsp48_pkg;

    localparam string RST_SYNC  = "SYNC";
    localparam string RST_ASYNC = "ASYNC";

    localparam int OPERAND_W = 18;

    // Number of bits needed to encode values 0..n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_pipe_chain_if.sv
// Operand-path bundle for the latency-balancing delay line.
// master drives sample/control, slave returns the delayed sample.
interface reg_pipe_chain_if
    import dsp48_pkg::*;
#(
    parameter int reg_SIZE = OPERAND_W,
    parameter int DEPTH    = 4
);
    localparam int LAT_W = clog2(DEPTH + 1);

    logic                CE;
    logic [reg_SIZE-1:0] IN;
    logic                IN_VLD;
    logic                FLUSH;
    logic [LAT_W-1:0]    LAT;
    logic                LAT_LD;
    logic [reg_SIZE-1:0] out;
    logic                OUT_VLD;
    logic                LAT_ERR;

    modport master (
        output CE, IN, IN_VLD, FLUSH, LAT, LAT_LD,
        input  out, OUT_VLD, LAT_ERR
    );

    modport slave (
        input  CE, IN, IN_VLD, FLUSH, LAT, LAT_LD,
        output out, OUT_VLD, LAT_ERR
    );

endinterface

// File: rtl/reg_pipe_chain_pipe_stage.sv
// One data+valid register of the delay line.
// Data follows the enable; the valid bit can also be cleared on its own.
module pipe_stage #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         clr,
    input  logic [W-1:0] d_in,
    input  logic         v_in,
    output logic [W-1:0] d,
    output logic         v
);

    // Data shifts on enable only; clear wins over shift for the valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            d <= '0;
            v <= 1'b0;
        end else begin
            if (ce) begin
                d <= d_in;
            end
            if (clr) begin
                v <= 1'b0;
            end else if (ce) begin
                v <= v_in;
            end
        end
    end

endmodule

// File: rtl/reg_pipe_chain.sv
// Data+valid delay line with runtime latency 0..DEPTH.
// Latency changes drop in-flight valids so no sample is duplicated.
module reg_pipe_chain
    import dsp48_pkg::*;
#(
    parameter int reg_SIZE = OPERAND_W,
    parameter int DEPTH    = 4,
    parameter int LAT_RST  = 1
) (
    input  logic              clk,
    input  logic              rst,
    reg_pipe_chain_if.slave   bus
);

    localparam int LAT_W = clog2(DEPTH + 1);

    logic [reg_SIZE-1:0] sd [DEPTH];
    logic [reg_SIZE-1:0] din [DEPTH];
    logic [DEPTH-1:0]    sv;
    logic [DEPTH-1:0]    vin;

    logic [LAT_W-1:0]    lat_q;
    logic                err_q;
    logic [LAT_W-1:0]    lat_sat;
    logic                lat_big;
    logic                reload_flush;
    logic                clr;

    logic [reg_SIZE-1:0] out_mux;
    logic                vld_mux;

    assign lat_big      = bus.LAT > LAT_W'(DEPTH);
    assign lat_sat      = lat_big ? LAT_W'(DEPTH) : bus.LAT;
    assign reload_flush = bus.LAT_LD && (lat_sat != lat_q);
    assign clr          = bus.FLUSH | reload_flush;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign din[k] = bus.IN;
            assign vin[k] = bus.IN_VLD;
        end else begin : g_tail
            assign din[k] = sd[k-1];
            assign vin[k] = sv[k-1];
        end

        pipe_stage #(
            .W (reg_SIZE)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .ce   (bus.CE),
            .clr  (clr),
            .d_in (din[k]),
            .v_in (vin[k]),
            .d    (sd[k]),
            .v    (sv[k])
        );
    end

    // Latency register (saturating) and sticky out-of-range flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q <= LAT_W'(LAT_RST);
            err_q <= 1'b0;
        end else if (bus.LAT_LD) begin
            lat_q <= lat_sat;
            if (lat_big) begin
                err_q <= 1'b1;
            end
        end
    end

    // Tap select: latency 0 bypasses the registers entirely.
    always_comb begin
        out_mux = bus.IN;
        vld_mux = bus.IN_VLD;
        for (int k = 0; k < DEPTH; k++) begin
            if (lat_q == LAT_W'(k + 1)) begin
                out_mux = sd[k];
                vld_mux = sv[k];
            end
        end
    end

    assign bus.out     = out_mux;
    assign bus.OUT_VLD = vld_mux;
    assign bus.LAT_ERR = err_q;

endmodule

// File: tb/tb_reg_pipe_chain.sv
// Scoreboard bench for reg_pipe_chain (DEPTH=4, LAT_RST=0).
// Reference keeps a history list of enabled samples and taps it by latency.
module tb_reg_pipe_chain;

    localparam int W       = 18;
    localparam int DEPTH   = 4;
    localparam int LAT_RST = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         v;
    } smp_t;

    typedef struct {
        logic [W-1:0] d;
        logic         v;
        logic         e;
    } exp_t;

    logic clk;
    logic rst;

    reg_pipe_chain_if #(.reg_SIZE(W), .DEPTH(DEPTH)) bus ();

    reg_pipe_chain #(
        .reg_SIZE (W),
        .DEPTH    (DEPTH),
        .LAT_RST  (LAT_RST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    exp_t sbq[$];
    smp_t hist[$];
    int   lat_m;
    bit   err_m;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        smp_t z;
        z.d = '0;
        z.v = 1'b0;
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back(z);
        lat_m = LAT_RST;
        err_m = 1'b0;
    endtask

    // One clock: apply inputs, queue expectation, advance model at edge.
    task automatic step(input bit r, input bit ce, input logic [W-1:0] din,
                        input bit vld, input bit fl, input int lat,
                        input bit ld);
        exp_t e;
        smp_t s;
        int   sat;
        bit   clr;
        rst        = r;
        bus.CE     = ce;
        bus.IN     = din;
        bus.IN_VLD = vld;
        bus.FLUSH  = fl;
        bus.LAT    = 3'(lat);
        bus.LAT_LD = ld;
        if (lat_m == 0) begin
            e.d = din;
            e.v = vld;
        end else begin
            e.d = hist[lat_m-1].d;
            e.v = hist[lat_m-1].v;
        end
        e.e = err_m;
        sbq.push_back(e);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            sat = (lat > DEPTH) ? DEPTH : lat;
            clr = fl || (ld && sat != lat_m);
            if (ce) begin
                s.d = din;
                s.v = vld;
                hist.push_front(s);
                void'(hist.pop_back());
            end
            if (clr) foreach (hist[i]) hist[i].v = 1'b0;
            if (ld) begin
                lat_m = sat;
                if (lat > DEPTH) err_m = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit ce);
        for (int i = 0; i < n; i++) step(0, ce, W'($urandom), 0, 0, 0, 0);
    endtask

    task automatic load(input int lat);
        step(0, 0, W'($urandom), 0, 0, lat, 1);
    endtask

    task automatic put(input logic [W-1:0] din);
        step(0, 1, din, 1, 0, 0, 0);
    endtask

    // Monitor: compare DUT outputs against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks += 3;
                if (bus.out !== e.d) begin
                    failures++;
                    $display("FAIL out t=%0t got=%h exp=%h",
                             $time, bus.out, e.d);
                end
                if (bus.OUT_VLD !== e.v) begin
                    failures++;
                    $display("FAIL out_vld t=%0t got=%b exp=%b",
                             $time, bus.OUT_VLD, e.v);
                end
                if (bus.LAT_ERR !== e.e) begin
                    failures++;
                    $display("FAIL lat_err t=%0t got=%b exp=%b",
                             $time, bus.LAT_ERR, e.e);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by random traffic.
    initial begin
        model_reset();
        rst        = 1'b1;
        bus.CE     = 1'b0;
        bus.IN     = '0;
        bus.IN_VLD = 1'b0;
        bus.FLUSH  = 1'b0;
        bus.LAT    = '0;
        bus.LAT_LD = 1'b0;
        @(posedge clk);
        #1;

        // Reset with bypass, then load 3 and stream 1,2,3.
        step(1, 1, 18'h1234, 1, 0, 0, 0);
        step(1, 0, 18'h1234, 1, 0, 0, 0);
        step(0, 1, 18'h0, 0, 0, 3, 1);
        put(18'd1);
        put(18'd2);
        put(18'd3);
        idle(5, 1);

        // Latency sweep with a single all-ones sample.
        for (int l = 1; l <= DEPTH; l++) begin
            load(l);
            put(18'h3FFFF);
            idle(6, 1);
        end

        // CE stall between B and C at latency 2.
        load(2);
        put(18'h0A0A);
        put(18'h0B0B);
        idle(3, 0);
        put(18'h0C0C);
        idle(4, 1);

        // Flush with four samples in flight at latency 4.
        load(4);
        for (int i = 0; i < 4; i++) put(18'(16 + i));
        step(0, 1, 18'h55, 1, 1, 0, 0);
        put(18'h66);
        idle(6, 1);

        // Reload same value, new value, and out-of-range value.
        load(2);
        put(18'h101);
        put(18'h102);
        step(0, 1, 18'h103, 1, 0, 2, 1);
        put(18'h104);
        step(0, 1, 18'h105, 1, 0, 3, 1);
        for (int i = 0; i < 4; i++) put(18'(18'h110 + i));
        idle(4, 1);
        step(0, 1, 18'h120, 1, 0, 7, 1);
        idle(3, 1);
        load(3);
        idle(2, 1);

        // Reset with samples in flight at latency 3.
        put(18'h201);
        put(18'h202);
        put(18'h203);
        step(1, 1, 18'h204, 1, 0, 0, 0);
        idle(3, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 75),
                 W'($urandom),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 99) < 8),
                 $urandom_range(0, 7),
                 ($urandom_range(0, 99) < 10));
        end
        idle(2, 1);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
